// File: rtl/bsearch_pkg.sv
// rtl/bsearch_pkg.sv - shared constants, types and loader states for the binary-search memory
package bsearch_pkg;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [ADDR_W:0]   cnt_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CLEAR = 2'd2
    } loader_state_t;

    localparam cnt_t DEPTH_CNT = cnt_t'(DEPTH);
    localparam cnt_t LAST_CNT  = cnt_t'(DEPTH - 1);
endpackage

// File: rtl/sorted_insert_loader_if.sv
// rtl/sorted_insert_loader_if.sv - value-insert handshake between producer and loader
interface sorted_insert_loader_if;
    import bsearch_pkg::*;

    data_t in_data;
    logic  in_valid;
    logic  in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/sorted_insert_loader_mem.sv
// rtl/sorted_insert_loader_mem.sv - DEPTH x DATA_W array: one write port, compare tap, registered read
module sorted_mem
    import bsearch_pkg::*;
(
    input  logic  clock,
    input  logic  reset,
    input  logic  we,
    input  addr_t waddr,
    input  data_t wdata,
    input  addr_t tap_addr,
    output data_t tap_data,
    input  addr_t rd_addr,
    output data_t rd_data
);
    data_t mem [DEPTH];

    // Contents are deliberately not reset; the loader's count defines validity.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign tap_data = mem[tap_addr];

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end
endmodule

// File: rtl/sorted_insert_loader.sv
// rtl/sorted_insert_loader.sv - shift-up sorted insert into a 32-entry array; LOADER_CLEAR_EN adds a zeroing clear
module sorted_insert_loader
    import bsearch_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    sorted_insert_loader_if.slave in_if,
`ifdef LOADER_CLEAR_EN
    input  logic                  clear,
`endif
    output logic                  busy,
    output logic                  full,
    output cnt_t                  count,
    input  addr_t                 rd_addr,
    output data_t                 rd_data
);
    loader_state_t state;
    cnt_t          ptr;
    data_t         val;

    logic  we;
    addr_t waddr;
    data_t wdata;
    addr_t tap_addr;
    data_t tap_data;
    logic  stop;

    assign busy           = (state != IDLE);
    assign full           = (count == DEPTH_CNT);
    assign in_if.in_ready = (state == IDLE) && !full;

    assign tap_addr = ptr[ADDR_W-1:0] - 1'b1;
    // Equal entries stay below the new value, keeping duplicates in arrival order.
    assign stop     = (ptr == '0) || (tap_data <= val);

    always_comb begin
        we    = 1'b0;
        waddr = ptr[ADDR_W-1:0];
        wdata = val;
        case (state)
            SHIFT: begin
                we    = !reset;
                wdata = stop ? val : tap_data;
            end
`ifdef LOADER_CLEAR_EN
            CLEAR: begin
                we    = !reset;
                wdata = '0;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            ptr   <= '0;
            val   <= '0;
        end else begin
            case (state)
                IDLE: begin
`ifdef LOADER_CLEAR_EN
                    if (clear) begin
                        state <= CLEAR;
                        count <= '0;
                        ptr   <= '0;
                    end else
`endif
                    if (in_if.in_valid && in_if.in_ready) begin
                        val   <= in_if.in_data;
                        ptr   <= count;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (stop) begin
                        count <= count + 1'b1;
                        state <= IDLE;
                    end else begin
                        ptr <= ptr - 1'b1;
                    end
                end
`ifdef LOADER_CLEAR_EN
                CLEAR: begin
                    if (ptr == LAST_CNT) begin
                        state <= IDLE;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    sorted_mem u_mem (
        .clock    (clock),
        .reset    (reset),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .tap_addr (tap_addr),
        .tap_data (tap_data),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data)
    );
endmodule

// File: tb/tb_sorted_insert_loader.sv
// tb/tb_sorted_insert_loader.sv - directed self-checking bench for sorted_insert_loader
module tb_sorted_insert_loader;
    import bsearch_pkg::*;

    logic  clock = 1'b0;
    logic  reset;
    logic  busy;
    logic  full;
    cnt_t  count;
    addr_t rd_addr;
    data_t rd_data;
`ifdef LOADER_CLEAR_EN
    logic  clear;
`endif

    int errors = 0;
    int checks = 0;

    sorted_insert_loader_if lif ();

    sorted_insert_loader dut (
        .clock   (clock),
        .reset   (reset),
        .in_if   (lif),
`ifdef LOADER_CLEAR_EN
        .clear   (clear),
`endif
        .busy    (busy),
        .full    (full),
        .count   (count),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_busy(output int n);
        n = 0;
        while (busy && n < 200) begin
            n++;
            tick();
        end
    endtask

    task automatic insert(input data_t v, output int n);
        int w;
        w = 0;
        while (!lif.in_ready && w < 200) begin
            w++;
            tick();
        end
        check("ready_wait", {31'd0, lif.in_ready}, 32'd1);
        lif.in_data  = v;
        lif.in_valid = 1'b1;
        tick();
        lif.in_valid = 1'b0;
        wait_busy(n);
    endtask

    task automatic rd(input addr_t a, output data_t d);
        rd_addr = a;
        tick();
        d = rd_data;
    endtask

    initial begin
        int    n;
        data_t d;
        data_t exp3 [3] = '{8'd10, 8'd30, 8'd50};
        data_t exp4 [4] = '{8'd10, 8'd20, 8'd20, 8'd30};
        int    lat3 [3] = '{1, 2, 2};
        data_t ins3 [3] = '{8'd50, 8'd10, 8'd30};

        lif.in_data  = '0;
        lif.in_valid = 1'b0;
        rd_addr      = '0;
`ifdef LOADER_CLEAR_EN
        clear        = 1'b0;
`endif
        do_reset();

        check("rst_count", 32'(count), 32'd0);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ready", {31'd0, lif.in_ready}, 32'd1);
        check("rst_rd_data", 32'(rd_data), 32'd0);

        for (int i = 0; i < 3; i++) begin
            insert(ins3[i], n);
            check($sformatf("lat3_%0d", i), 32'(n), 32'(lat3[i]));
        end
        check("count3", 32'(count), 32'd3);
        for (int i = 0; i < 3; i++) begin
            rd(addr_t'(i), d);
            check($sformatf("mem3_%0d", i), 32'(d), 32'(exp3[i]));
        end

        do_reset();
        for (int v = 31; v >= 0; v--) begin
            insert(data_t'(v), n);
            check($sformatf("desc_lat_%0d", v), 32'(n), 32'(32 - v));
        end
        check("desc_count", 32'(count), 32'd32);
        check("desc_full", {31'd0, full}, 32'd1);
        check("desc_ready", {31'd0, lif.in_ready}, 32'd0);
        lif.in_data  = 8'd99;
        lif.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("full_ignore_busy", {31'd0, busy}, 32'd0);
        end
        lif.in_valid = 1'b0;
        check("full_ignore_count", 32'(count), 32'd32);
        for (int i = 0; i < 32; i++) begin
            rd(addr_t'(i), d);
            check($sformatf("desc_mem_%0d", i), 32'(d), 32'(i));
        end

        do_reset();
        insert(8'd10, n);
        insert(8'd20, n);
        insert(8'd30, n);
        insert(8'd20, n);
        check("dup_lat", 32'(n), 32'd2);
        check("dup_count", 32'(count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            rd(addr_t'(i), d);
            check($sformatf("dup_mem_%0d", i), 32'(d), 32'(exp4[i]));
        end

        do_reset();
        insert(8'd10, n);
        insert(8'd20, n);
        insert(8'd30, n);
        lif.in_data  = 8'd5;
        lif.in_valid = 1'b1;
        tick();
        lif.in_valid = 1'b0;
        check("abort_busy1", {31'd0, busy}, 32'd1);
        tick();
        check("abort_busy2", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_count", 32'(count), 32'd0);
        check("abort_ready", {31'd0, lif.in_ready}, 32'd1);
        insert(8'd7, n);
        check("abort_lat", 32'(n), 32'd1);
        check("abort_count1", 32'(count), 32'd1);
        rd(addr_t'(0), d);
        check("abort_mem0", 32'(d), 32'd7);

`ifdef LOADER_CLEAR_EN
        do_reset();
        insert(8'd4, n);
        insert(8'd3, n);
        insert(8'd2, n);
        insert(8'd1, n);
        check("clr_pre_count", 32'(count), 32'd4);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_count_entry", 32'(count), 32'd0);
        check("clr_ready_busy", {31'd0, lif.in_ready}, 32'd0);
        wait_busy(n);
        check("clr_lat", 32'(n), 32'd32);
        check("clr_ready", {31'd0, lif.in_ready}, 32'd1);
        for (int i = 0; i < 32; i++) begin
            rd(addr_t'(i), d);
            check($sformatf("clr_mem_%0d", i), 32'(d), 32'd0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
